// File: rtl/icache_controller.sv
// Direct-mapped, read-only instruction cache with 4-word blocks; misses stall the PC via BUSYWAIT.
// Define ICACHE_STATS_EN to add saturating HIT_COUNT / MISS_COUNT outputs.
module icache_controller #(
  parameter int NUM_BLOCKS = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [31:0]           PC,
  output logic [31:0]           INSTRUCTION,
  output logic                  BUSYWAIT,
  output logic                  MEM_READ,
  output logic [ADDR_WIDTH-5:0] MEM_ADDRESS,
  input  logic [127:0]          MEM_READDATA,
  input  logic                  MEM_BUSYWAIT
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0]           HIT_COUNT,
  output logic [15:0]           MISS_COUNT
`endif
);

  localparam int INDEX_W = $clog2(NUM_BLOCKS);
  localparam int TAG_W   = ADDR_WIDTH - INDEX_W - 4;

  typedef enum logic [1:0] {IDLE, FETCH, UPDATE} state_t;

  state_t state, next_state;

  logic [NUM_BLOCKS-1:0] valid;
  logic [TAG_W-1:0]      tag_array  [NUM_BLOCKS];
  logic [127:0]          data_array [NUM_BLOCKS];

  logic [1:0]         pc_offset;
  logic [INDEX_W-1:0] pc_index;
  logic [TAG_W-1:0]   pc_tag;
  logic [INDEX_W-1:0] fill_index;
  logic [TAG_W-1:0]   fill_tag;
  logic [127:0]       line_data;
  logic               hit;
  logic               latch_miss;
  logic               unused_pc_bits;

  assign pc_offset      = PC[3:2];
  assign pc_index       = PC[3+INDEX_W:4];
  assign pc_tag         = PC[ADDR_WIDTH-1:4+INDEX_W];
  assign unused_pc_bits = ^{PC[31:ADDR_WIDTH], PC[1:0]};

  // The latched block address doubles as the fill target, so a PC that moves mid-fill cannot corrupt it.
  assign fill_index = MEM_ADDRESS[INDEX_W-1:0];
  assign fill_tag   = MEM_ADDRESS[ADDR_WIDTH-5:INDEX_W];

  assign hit       = valid[pc_index] && (tag_array[pc_index] == pc_tag);
  assign line_data = data_array[pc_index];

  always_comb begin
    INSTRUCTION = '0;
    if (hit) begin
      case (pc_offset)
        2'd0:    INSTRUCTION = line_data[31:0];
        2'd1:    INSTRUCTION = line_data[63:32];
        2'd2:    INSTRUCTION = line_data[95:64];
        default: INSTRUCTION = line_data[127:96];
      endcase
    end
  end

  always_comb begin
    next_state = state;
    BUSYWAIT   = 1'b0;
    MEM_READ   = 1'b0;
    latch_miss = 1'b0;
    case (state)
      IDLE: begin
        if (!hit) begin
          BUSYWAIT   = 1'b1;
          latch_miss = 1'b1;
          next_state = FETCH;
        end
      end
      FETCH: begin
        BUSYWAIT = 1'b1;
        MEM_READ = 1'b1;
        if (!MEM_BUSYWAIT) next_state = UPDATE;
      end
      UPDATE: begin
        BUSYWAIT   = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    // The pipeline must not stall while the cache itself is held in reset.
    if (!RESET_N) BUSYWAIT = 1'b0;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= IDLE;
      MEM_ADDRESS <= '0;
      valid       <= '0;
    end else begin
      state <= next_state;
      if (latch_miss) MEM_ADDRESS <= {pc_tag, pc_index};
      if (state == UPDATE) valid[fill_index] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; the valid bits alone decide whether a line is usable.
  always_ff @(posedge CLK) begin
    if (state == UPDATE) begin
      tag_array[fill_index]  <= fill_tag;
      data_array[fill_index] <= MEM_READDATA;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      HIT_COUNT  <= '0;
      MISS_COUNT <= '0;
    end else begin
      if ((state == IDLE) && hit && (HIT_COUNT != 16'hFFFF)) HIT_COUNT <= HIT_COUNT + 16'd1;
      if (latch_miss && (MISS_COUNT != 16'hFFFF)) MISS_COUNT <= MISS_COUNT + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_controller.sv
// Self-checking bench for icache_controller: 5-cycle memory model, per-cycle reference model, directed cases.
// Exercises the HIT_COUNT / MISS_COUNT outputs when ICACHE_STATS_EN is defined.
module tb_icache_controller;

  localparam int LAT = 5;

  logic         CLK;
  logic         RESET_N;
  logic [31:0]  PC;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [5:0]   MEM_ADDRESS;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;
`ifdef ICACHE_STATS_EN
  logic [15:0]  HIT_COUNT;
  logic [15:0]  MISS_COUNT;
`endif

  int total_checks = 0;
  int passed_checks = 0;

  icache_controller dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .PC           (PC),
    .INSTRUCTION  (INSTRUCTION),
    .BUSYWAIT     (BUSYWAIT),
    .MEM_READ     (MEM_READ),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT)
`ifdef ICACHE_STATS_EN
    ,
    .HIT_COUNT    (HIT_COUNT),
    .MISS_COUNT   (MISS_COUNT)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] pattern(input int blk, input int word);
    return 32'hC000_0000 | (32'(blk) << 16) | 32'(word);
  endfunction

  function automatic logic [127:0] block_data(input logic [5:0] blk);
    logic [127:0] d;
    for (int i = 0; i < 4; i++) d[i*32 +: 32] = pattern(int'(blk), i);
    return d;
  endfunction

  // Memory: read data is ready on the LAT-th cycle MEM_READ is held high.
  int mem_cnt = 0;
  always @(posedge CLK) mem_cnt <= MEM_READ ? mem_cnt + 1 : 0;
  assign MEM_BUSYWAIT = MEM_READ && (mem_cnt < LAT - 1);
  assign MEM_READDATA = block_data(MEM_ADDRESS);

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total_checks++;
    if (actual === expected) passed_checks++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  // Reference model: line contents as block numbers, plus the age of an outstanding fill.
  bit        m_valid [8];
  int        m_tag   [8];
  int        m_fill_age = 0;
  int        m_addr = 0;
  int        m_hits = 0;
  int        m_misses = 0;
  int        m_idx, m_tg, m_off;
  bit        m_hit;
  logic [31:0] e_inst;
  logic        e_busy, e_read;

  always @(negedge CLK) begin
    m_idx = int'(PC[6:4]);
    m_tg  = int'(PC[9:7]);
    m_off = int'(PC[3:2]);
    if (!RESET_N) begin
      for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
      m_fill_age = 0;
      m_addr     = 0;
      m_hits     = 0;
      m_misses   = 0;
      checkOutput("model_reset_busywait", 32'(BUSYWAIT), 32'd0);
      checkOutput("model_reset_mem_read", 32'(MEM_READ), 32'd0);
      checkOutput("model_reset_mem_address", 32'(MEM_ADDRESS), 32'd0);
      checkOutput("model_reset_instruction", INSTRUCTION, 32'd0);
    end else begin
      m_hit  = m_valid[m_idx] && (m_tag[m_idx] == m_tg);
      e_inst = m_hit ? pattern(m_tg * 8 + m_idx, m_off) : 32'd0;
      if (m_fill_age > 0) begin
        e_busy = 1'b1;
        e_read = (m_fill_age <= LAT);
      end else begin
        e_busy = !m_hit;
        e_read = 1'b0;
      end
      checkOutput("model_busywait", 32'(BUSYWAIT), 32'(e_busy));
      checkOutput("model_mem_read", 32'(MEM_READ), 32'(e_read));
      checkOutput("model_mem_address", 32'(MEM_ADDRESS), 32'(m_addr));
      checkOutput("model_instruction", INSTRUCTION, e_inst);
`ifdef ICACHE_STATS_EN
      checkOutput("model_hit_count", 32'(HIT_COUNT), 32'(m_hits));
      checkOutput("model_miss_count", 32'(MISS_COUNT), 32'(m_misses));
`endif
      if (m_fill_age > 0) begin
        if (m_fill_age == LAT + 1) begin
          m_valid[m_addr % 8] = 1'b1;
          m_tag[m_addr % 8]   = m_addr / 8;
          m_fill_age          = 0;
        end else begin
          m_fill_age++;
        end
      end else if (m_hit) begin
        if (m_hits < 16'hFFFF) m_hits++;
      end else begin
        m_addr     = m_tg * 8 + m_idx;
        m_fill_age = 1;
        if (m_misses < 16'hFFFF) m_misses++;
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] pc);
    @(posedge CLK);
    #1;
    PC = pc;
  endtask

  task automatic hitAt(input logic [31:0] pc, input logic [31:0] exp_word);
    applyStimulus(pc);
    @(negedge CLK);
    checkOutput("hit_instruction", INSTRUCTION, exp_word);
    checkOutput("hit_busywait", 32'(BUSYWAIT), 32'd0);
    checkOutput("hit_mem_read", 32'(MEM_READ), 32'd0);
  endtask

  task automatic missAndFill(input logic [31:0] pc, input logic [5:0] exp_addr, input logic [31:0] exp_word);
    int n;
    @(posedge CLK);
    #1;
    RESET_N = 1'b1;
    PC      = pc;
    @(negedge CLK);
    checkOutput("miss_busywait", 32'(BUSYWAIT), 32'd1);
    checkOutput("miss_instruction", INSTRUCTION, 32'd0);
    @(negedge CLK);
    checkOutput("fetch_mem_read", 32'(MEM_READ), 32'd1);
    checkOutput("fetch_mem_address", 32'(MEM_ADDRESS), 32'(exp_addr));
    n = 1;
    while (BUSYWAIT && n < 50) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("miss_penalty_cycles", 32'(n), 32'd7);
    checkOutput("fill_instruction", INSTRUCTION, exp_word);
    checkOutput("fill_busywait", 32'(BUSYWAIT), 32'd0);
  endtask

  initial begin
    RESET_N = 1'b0;
    PC      = 32'h0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checkOutput("reset_mem_address", 32'(MEM_ADDRESS), 32'd0);
    checkOutput("reset_busywait", 32'(BUSYWAIT), 32'd0);

    // Cold miss, then spatial hits across the rest of block 0
    missAndFill(32'h000, 6'h00, 32'hC000_0000);
    hitAt(32'h004, 32'hC000_0001);
    hitAt(32'h008, 32'hC000_0002);
    hitAt(32'h00C, 32'hC000_0003);
`ifdef ICACHE_STATS_EN
    @(posedge CLK);
    #1;
    checkOutput("stats_hit_count", 32'(HIT_COUNT), 32'd4);
    checkOutput("stats_miss_count", 32'(MISS_COUNT), 32'd1);
`endif

    // Conflict on index 0: each fill evicts the other
    missAndFill(32'h080, 6'h08, 32'hC008_0000);
    missAndFill(32'h000, 6'h00, 32'hC000_0000);

    // Reset lands in the third cycle of a miss; the line must stay invalid
    applyStimulus(32'h040);
    @(negedge CLK);
    checkOutput("abort_miss_busywait", 32'(BUSYWAIT), 32'd1);
    @(posedge CLK);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RESET_N = 1'b0;
    @(negedge CLK);
    checkOutput("abort_mem_read", 32'(MEM_READ), 32'd0);
    checkOutput("abort_busywait", 32'(BUSYWAIT), 32'd0);
    checkOutput("abort_mem_address", 32'(MEM_ADDRESS), 32'd0);
    missAndFill(32'h040, 6'h04, 32'hC004_0000);

    // Index 7 with tags 0 and 7; upper PC bits and PC[1:0] must not matter
    missAndFill(32'h070, 6'h07, 32'hC007_0000);
    missAndFill(32'h3F0, 6'h3F, 32'hC03F_0000);
    hitAt(32'hFFFF_FFF4, 32'hC03F_0001);
    missAndFill(32'hFFFF_FC70, 6'h07, 32'hC007_0000);
    hitAt(32'h074, 32'hC007_0001);
    hitAt(32'h077, 32'hC007_0001);

`ifdef ICACHE_STATS_EN
    repeat (70000) @(posedge CLK);
    #1;
    checkOutput("stats_hit_saturate", 32'(HIT_COUNT), 32'h0000_FFFF);
`endif

    @(negedge CLK);
    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
